// File: rtl/axis_divider_pkg.sv
// rtl/axis_divider_pkg.sv - shared constants and stage record for axis_divider; AXIS_DIVIDER_SIGNED_EN selects signed mode
package axis_divider_pkg;

   localparam int DIV_WIDTH = 32;

   function automatic int latency(input int width);
      return width + 2;
   endfunction

   localparam logic [DIV_WIDTH-1:0] DIV0_QUO   = '1;
   localparam logic [DIV_WIDTH-1:0] SIGNED_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

   // acc starts as the dividend magnitude; each stage shifts one dividend bit
   // out of the top and one quotient bit in at the bottom, so after the last
   // stage acc holds the quotient magnitude
   typedef struct packed {
      logic                 valid;
      logic [DIV_WIDTH-1:0] rem;
      logic [DIV_WIDTH-1:0] acc;
      logic [DIV_WIDTH-1:0] dvs;
`ifdef AXIS_DIVIDER_SIGNED_EN
      logic                 neg_q;
      logic                 neg_r;
`endif
      logic [DIV_WIDTH-1:0] dvd_orig;
   } stage_t;

endpackage

// File: rtl/axis_divider_if.sv
// rtl/axis_divider_if.sv - operand and result streams of axis_divider
interface axis_divider_if
   import axis_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) ();

   logic               s_axis_dividend_tvalid;
   logic [WIDTH-1:0]   s_axis_dividend_tdata;
   logic               s_axis_divisor_tvalid;
   logic [WIDTH-1:0]   s_axis_divisor_tdata;
   logic               m_axis_dout_tvalid;
   logic [2*WIDTH-1:0] m_axis_dout_tdata;

   modport slave (
      input  s_axis_dividend_tvalid,
      input  s_axis_dividend_tdata,
      input  s_axis_divisor_tvalid,
      input  s_axis_divisor_tdata,
      output m_axis_dout_tvalid,
      output m_axis_dout_tdata
   );

   modport master (
      output s_axis_dividend_tvalid,
      output s_axis_dividend_tdata,
      output s_axis_divisor_tvalid,
      output s_axis_divisor_tdata,
      input  m_axis_dout_tvalid,
      input  m_axis_dout_tdata
   );

endinterface

// File: rtl/axis_divider_stage.sv
// rtl/axis_divider_stage.sv - one restoring subtract/shift step with its stage register
module divider_stage
   import axis_divider_pkg::*;
(
   input  logic   aclk,
   input  logic   aresetn,
   input  stage_t i_stage,
   output stage_t o_stage
);

   localparam int W = DIV_WIDTH;

   logic [W:0] w_shift;
   logic       w_fits;
   stage_t     w_next;
   stage_t     r_stage;

   // bring down the next dividend bit and subtract the divisor if it fits;
   // the true difference is always below 2^W, so a W-bit subtract is exact
   always_comb begin
      w_next      = i_stage;
      w_shift     = {i_stage.rem, i_stage.acc[W-1]};
      w_fits      = (w_shift >= {1'b0, i_stage.dvs});
      w_next.rem  = w_fits ? (w_shift[W-1:0] - i_stage.dvs) : w_shift[W-1:0];
      w_next.acc  = {i_stage.acc[W-2:0], w_fits};
   end

   // stage register, advances every cycle
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_stage <= '0;
      end else begin
         r_stage <= w_next;
      end
   end

   assign o_stage = r_stage;

endmodule

// File: rtl/axis_divider.sv
// rtl/axis_divider.sv - pipelined restoring divider, {quotient, remainder} out; AXIS_DIVIDER_SIGNED_EN selects signed mode
module axis_divider
   import axis_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic           aclk,
   input  logic           aresetn,
   axis_divider_if.slave  bus
);

   localparam int LATENCY    = latency(WIDTH);
   localparam int NUM_STAGES = LATENCY - 2;

   logic [WIDTH-1:0] w_dvd;
   logic [WIDTH-1:0] w_dvs;
   stage_t           w_in;
   stage_t           r_in;
   stage_t           w_pipe [0:NUM_STAGES];
   stage_t           w_last;
   logic [WIDTH-1:0] w_quo;
   logic [WIDTH-1:0] w_rem;
   logic             r_fix_valid;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_rem;

   assign w_dvd = bus.s_axis_dividend_tdata;
   assign w_dvs = bus.s_axis_divisor_tdata;

   // accept only when both operands are valid together; signed operands
   // become magnitudes here, the signs ride along to the correction stage
   always_comb begin
      w_in          = '0;
      w_in.valid    = bus.s_axis_dividend_tvalid & bus.s_axis_divisor_tvalid;
      w_in.dvd_orig = w_dvd;
`ifdef AXIS_DIVIDER_SIGNED_EN
      w_in.acc      = w_dvd[WIDTH-1] ? -w_dvd : w_dvd;
      w_in.dvs      = w_dvs[WIDTH-1] ? -w_dvs : w_dvs;
      w_in.neg_q    = w_dvd[WIDTH-1] ^ w_dvs[WIDTH-1];
      w_in.neg_r    = w_dvd[WIDTH-1];
`else
      w_in.acc      = w_dvd;
      w_in.dvs      = w_dvs;
`endif
   end

   // input register stage
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_in <= '0;
      end else begin
         r_in <= w_in;
      end
   end

   assign w_pipe[0] = r_in;

   for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
      divider_stage u_stage (
         .aclk    (aclk),
         .aresetn (aresetn),
         .i_stage (w_pipe[g]),
         .o_stage (w_pipe[g+1])
      );
   end

   assign w_last = w_pipe[NUM_STAGES];

   // sign correction and special cases; a quotient magnitude of MIN only
   // arises from MIN / +-1, whose result is MIN with zero remainder
   always_comb begin
      w_quo = w_last.acc;
      w_rem = w_last.rem;
`ifdef AXIS_DIVIDER_SIGNED_EN
      if (w_last.neg_q) begin
         w_quo = -w_last.acc;
      end
      if (w_last.neg_r) begin
         w_rem = -w_last.rem;
      end
      if (w_last.acc == SIGNED_MIN) begin
         w_quo = SIGNED_MIN;
         w_rem = '0;
      end
`endif
      if (w_last.dvs == '0) begin
         w_quo = DIV0_QUO;
         w_rem = w_last.dvd_orig;
      end
   end

   // correction register keeps the negate adders away from the output
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_fix_valid <= 1'b0;
         r_quo       <= '0;
         r_rem       <= '0;
      end else begin
         r_fix_valid <= w_last.valid;
         r_quo       <= w_quo;
         r_rem       <= w_rem;
      end
   end

   // output register; data holds between result pulses
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         bus.m_axis_dout_tvalid <= 1'b0;
         bus.m_axis_dout_tdata  <= '0;
      end else begin
         bus.m_axis_dout_tvalid <= r_fix_valid;
         if (r_fix_valid) begin
            bus.m_axis_dout_tdata <= {r_quo, r_rem};
         end
      end
   end

endmodule

// File: tb/tb_axis_divider.sv
// tb/tb_axis_divider.sv - self-checking bench for axis_divider with a behavioural divide model
module tb_axis_divider;

   localparam int LAT = 34;

   typedef struct {
      int          due;
      logic [63:0] data;
   } exp_t;

   logic        aclk;
   logic        aresetn;
   int          checks;
   int          errors;
   int          cyc;
   exp_t        exp_q[$];
   logic [63:0] last_data;

   axis_divider_if #(.WIDTH(32)) bus ();

   axis_divider dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
      if (b == 32'd0) return {32'hFFFFFFFF, a};
`ifdef AXIS_DIVIDER_SIGNED_EN
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h80000000, 32'h0};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
`else
      q = a / b;
      r = a % b;
`endif
      return {q, r};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'($urandom_range(0, 20));
         5: return 32'($urandom_range(0, 65535));
         default: return $urandom;
      endcase
   endfunction

   // per-cycle compare against the model queue
   always @(negedge aclk) begin
      cyc++;
      if (!aresetn) begin
         chk("reset_tvalid", {63'd0, bus.m_axis_dout_tvalid}, 64'd0);
         chk("reset_tdata", bus.m_axis_dout_tdata, 64'd0);
         exp_q.delete();
         last_data = 64'd0;
      end else begin
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("result_tvalid", {63'd0, bus.m_axis_dout_tvalid}, 64'd1);
            chk("result_tdata", bus.m_axis_dout_tdata, exp_q[0].data);
            last_data = exp_q[0].data;
            void'(exp_q.pop_front());
         end else begin
            chk("idle_tvalid", {63'd0, bus.m_axis_dout_tvalid}, 64'd0);
            chk("hold_tdata", bus.m_axis_dout_tdata, last_data);
         end
         if (bus.s_axis_dividend_tvalid && bus.s_axis_divisor_tvalid) begin
            exp_q.push_back('{cyc + 1 + LAT,
                              model(bus.s_axis_dividend_tdata, bus.s_axis_divisor_tdata)});
         end
      end
   end

   task automatic step();
      @(posedge aclk);
      #2;
   endtask

   task automatic set_in(input logic va, input logic vb, input logic [31:0] a, input logic [31:0] b);
      bus.s_axis_dividend_tvalid = va;
      bus.s_axis_divisor_tvalid  = vb;
      bus.s_axis_dividend_tdata  = a;
      bus.s_axis_divisor_tdata   = b;
   endtask

   // one operation accepted at the next edge k; pulse expected only after edge k+34
   task automatic lit_check(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp);
      set_in(1'b1, 1'b1, a, b);
      step();
      set_in(1'b0, 1'b0, 32'd0, 32'd0);
      repeat (LAT - 1) @(posedge aclk);
      @(negedge aclk);
      chk({name, "_early"}, {63'd0, bus.m_axis_dout_tvalid}, 64'd0);
      @(negedge aclk);
      chk({name, "_valid"}, {63'd0, bus.m_axis_dout_tvalid}, 64'd1);
      chk({name, "_data"}, bus.m_axis_dout_tdata, exp);
      @(negedge aclk);
      chk({name, "_pulse_end"}, {63'd0, bus.m_axis_dout_tvalid}, 64'd0);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      last_data = 64'd0;
      aresetn   = 1'b0;
      set_in(1'b0, 1'b0, 32'd0, 32'd0);

      chk("model_100_7", model(32'd100, 32'd7), 64'h0000000E_00000002);
      chk("model_div0", model(32'd1234, 32'd0), 64'hFFFFFFFF_000004D2);
`ifdef AXIS_DIVIDER_SIGNED_EN
      chk("model_m7_2", model(32'hFFFFFFF9, 32'd2), 64'hFFFFFFFD_FFFFFFFF);
      chk("model_min_m1", model(32'h80000000, 32'hFFFFFFFF), 64'h80000000_00000000);
`else
      chk("model_max_2", model(32'hFFFFFFFF, 32'd2), 64'h7FFFFFFF_00000001);
`endif

      repeat (5) step();
      aresetn = 1'b1;

      lit_check("lat_100_7", 32'd100, 32'd7, 64'h0000000E_00000002);
      step();
      lit_check("div0_1234", 32'd1234, 32'd0, 64'hFFFFFFFF_000004D2);
      step();
`ifdef AXIS_DIVIDER_SIGNED_EN
      lit_check("s_m7_2", 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFD_FFFFFFFF);
      step();
      lit_check("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000);
`else
      lit_check("u_max_2", 32'hFFFFFFFF, 32'd2, 64'h7FFFFFFF_00000001);
`endif

      // three back-to-back operations plus lone operand pulses
      step();
      set_in(1'b1, 1'b1, 32'd1000, 32'd3);
      step();
      set_in(1'b1, 1'b1, 32'hFFFFFF00, 32'd7);
      step();
      set_in(1'b1, 1'b1, 32'd12345678, 32'd0);
      step();
      set_in(1'b1, 1'b0, 32'd55, 32'd5);
      step();
      set_in(1'b0, 1'b1, 32'd66, 32'd6);
      step();
      set_in(1'b0, 1'b0, 32'd0, 32'd0);
      repeat (LAT + 4) step();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, pick(), pick());
         step();
      end
      set_in(1'b0, 1'b0, 32'd0, 32'd0);
      repeat (LAT + 4) step();

      // reset mid-flight discards everything; valid during reset is ignored
      set_in(1'b1, 1'b1, 32'd500, 32'd3);
      step();
      set_in(1'b1, 1'b1, 32'd77, 32'd4);
      step();
      set_in(1'b0, 1'b0, 32'd0, 32'd0);
      repeat (9) step();
      aresetn = 1'b0;
      set_in(1'b1, 1'b1, 32'd9, 32'd9);
      repeat (4) step();
      aresetn = 1'b1;
      lit_check("after_reset", 32'd1000, 32'd10, 64'h00000064_00000000);

      repeat (LAT + 6) step();
      chk("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
